wb_uart_txdma: RTL
==================

Name: wb_uart_txdma

Overview:
- Wishbone-controlled transmit sequencer that streams a byte buffer from memory into the wb_uart TX FIFO without CPU involvement.
- The CPU programs source address and length through a small slave register port, then sets start.
- The block fetches 32-bit words over a memory master port and polls the UART status register over a second master port.
- It writes each byte to the UART data register when tx_full is clear, and raises irq when the buffer is drained.

Parameters:
- LEN_W, 16, width of the length/remaining-byte counter.
- POLL_GAP, 4, idle cycles inserted after a poll that found tx_full=1 before re-polling (0 allowed).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- cyc_i  in  1  slave cycle
- stb_i  in  1  slave strobe
- adr_i  in  2  slave register select
- we_i  in  1  slave write enable
- dat_i  in  32  slave write data
- sel_i  in  4  slave byte selects (ignored, full-word access)
- ack_o  out  1  slave acknowledge
- dat_o  out  32  slave read data
- m_cyc_o, m_stb_o  out  1  memory master cycle/strobe
- m_adr_o  out  30  memory word address (byte address [31:2])
- m_ack_i  in  1  memory acknowledge
- m_dat_i  in  32  memory read data
- u_cyc_o, u_stb_o  out  1  UART master cycle/strobe
- u_adr_o  out  2  UART register select (0 = data, 1 = status)
- u_we_o  out  1  UART write enable
- u_dat_o  out  32  UART write data, byte in [31:24], [23:0] zero
- u_sel_o  out  4  constant 4'b1000
- u_ack_i  in  1  UART acknowledge
- u_dat_i  in  32  UART read data, status byte in [31:24]
- irq  out  1  done interrupt

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous, active-high.
- Reset values: all outputs 0 except u_sel_o. SRC=0, LEN=0, busy=0, done=0, irq_en=0, FSM in IDLE.
- Slave ack_o protocol:
  - ack_o <= 0 if ack_o is already 1, else ack_o <= stb_i. This gives a one-cycle pulse, one cycle after stb_i.
  - Writes take effect in the ack cycle.
  - dat_o is combinational from adr_i.
- Slave register map:
  - adr 0 SRC: byte address. Reads return the current address.
  - adr 1 LEN: [LEN_W-1:0]. Reads return remaining bytes.
  - adr 2 CTRL:
    - bit0 start: write 1 starts a transfer; reads return busy.
    - bit1 done: read; write 1 clears it (W1C).
    - bit2 irq_en: read/write.
    - bit3 abort: write 1 aborts.
  - adr 3: reads 0, writes ignored.
  - Writes to SRC/LEN while busy are ignored.
- Start handling:
  - start while busy is ignored.
  - start with LEN=0 sets done without any bus activity.
  - Otherwise start sets busy=1, clears done, and the FSM leaves IDLE.
- Master handshake (both ports):
  - cyc/stb/adr/we/dat are registered.
  - They stay asserted until ack is sampled, then drop in the next cycle.
  - There is at least one idle cycle between strobes, so the UART never sees stb high in the cycle after its ack and cannot double-write.
- FSM states:
  - IDLE
  - FETCH: m_adr_o=SRC[31:2]; latch m_dat_i into the word buffer on m_ack_i.
  - POLL: u_adr_o=1, u_we_o=0.
    - On u_ack_i, test u_dat_i[27] (tx_full).
    - tx_full=1: go to WAIT for POLL_GAP cycles, then back to POLL.
    - tx_full=0: go to WRITE.
  - WRITE: u_adr_o=1'b0 value 0, u_we_o=1, u_dat_o[31:24] = selected byte.
    - On u_ack_i: SRC+=1, LEN-=1.
    - If LEN becomes 0: go to DONE.
    - Else if the new SRC[1:0]==0: go to FETCH.
    - Else: go to POLL.
  - DONE: busy=0, done=1, return to IDLE.
- Byte lane selection is big-endian: SRC[1:0]=0 selects [31:24], 1 selects [23:16], 2 selects [15:8], 3 selects [7:0].
  - An unaligned SRC fetches once, then sends the remaining bytes of that word.
- SRC wraps modulo 2^32. LEN never underflows.
- Abort:
  - Any in-flight master cycle completes (waits for its ack).
  - A WRITE that is acked still decrements LEN.
  - Then the FSM goes to IDLE with busy=0 and done=1; LEN holds the untransmitted count.
  - Abort while IDLE has no effect.
- irq = done & irq_en.
- A simultaneous W1C of done and start: start wins, done=0.
- rst_i mid-transfer:
  - All state returns to reset values next cycle; master strobes drop immediately.
  - Slaves must tolerate the truncated cycle; the UART does.

Test Plan:
- SRC=0x100, LEN=5, memory[0x100]=0x48656C6C, [0x104]=0x6F000000, UART never full -> two fetches (0x40, 0x41), five writes 0x48,0x65,0x6C,0x6C,0x6F in order, then done=1 and LEN reads 0.
- SRC=0x103, LEN=2, memory[0x100]=0x000000AA, [0x104]=0xBB000000 -> writes 0xAA then 0xBB; fetch addresses 0x40 then 0x41.
- UART status returns tx_full=1 for 3 polls, then 0, POLL_GAP=4 -> exactly 4 idle cycles between polls; exactly one write per byte; no double ack on the UART.
- Abort written after the 2nd byte of LEN=10 -> current cycle completes; busy=0, done=1, LEN reads 8 (or 7 if a WRITE was in flight); no further strobes.
- irq_en=1, LEN=1 transfer -> irq rises with done; CTRL write 0x2 clears done and irq; start with LEN=0 -> done=1 immediately with no m_stb_o/u_stb_o.
- Assert rst_i during a WRITE strobe -> next cycle all strobes 0, registers reset, irq=0; a subsequent start operates normally.

Source files
------------

// File: rtl/wb_uart_txdma.sv
// wb_uart_txdma: streams a memory byte buffer into the wb_uart TX FIFO.
// The CPU programs SRC/LEN and sets start. The block polls tx_full before each byte write.
module wb_uart_txdma #(
   parameter int LEN_W    = 16,
   parameter int POLL_GAP = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cyc_i,
   input  logic             stb_i,
   input  logic [1:0]       adr_i,
   input  logic             we_i,
   input  logic [31:0]      dat_i,
   input  logic [3:0]       sel_i,
   output logic             ack_o,
   output logic [31:0]      dat_o,
   output logic             m_cyc_o,
   output logic             m_stb_o,
   output logic [29:0]      m_adr_o,
   input  logic             m_ack_i,
   input  logic [31:0]      m_dat_i,
   output logic             u_cyc_o,
   output logic             u_stb_o,
   output logic [1:0]       u_adr_o,
   output logic             u_we_o,
   output logic [31:0]      u_dat_o,
   output logic [3:0]       u_sel_o,
   input  logic             u_ack_i,
   input  logic [31:0]      u_dat_i,
   output logic             irq
);
   typedef enum logic [2:0] {IDLE, FETCH, POLL, GAP, WRITE, DONE} state_t;
   state_t             state;
   logic [31:0]        src;
   logic [LEN_W-1:0]   len;
   logic               busy;
   logic               done;
   logic               irq_en;
   logic               ab;
   logic [31:0]        wbuf;
   logic [31:0]        cnt;
   logic               wr;
   logic [7:0]         cur_byte;
   logic               unused;
   assign unused   = ^{sel_i, u_dat_i[31:28], u_dat_i[26:0]};
   assign wr       = cyc_i & stb_i & we_i & ack_o;
   assign u_sel_o  = 4'b1000;
   assign irq      = done & irq_en;
   assign cur_byte = src[1:0] == 2'd0 ? wbuf[31:24] :
                     src[1:0] == 2'd1 ? wbuf[23:16] :
                     src[1:0] == 2'd2 ? wbuf[15:8]  : wbuf[7:0];
   assign dat_o    = adr_i == 2'd0 ? src :
                     adr_i == 2'd1 ? 32'(len) :
                     adr_i == 2'd2 ? {29'b0, irq_en, done, busy} : 32'b0;
   // Slave writes are applied before the FSM so a completing transfer's done wins over a W1C
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_o   <= 1'b0;
         state   <= IDLE;
         src     <= '0;
         len     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         irq_en  <= 1'b0;
         ab      <= 1'b0;
         wbuf    <= '0;
         cnt     <= '0;
         m_cyc_o <= 1'b0;
         m_stb_o <= 1'b0;
         m_adr_o <= '0;
         u_cyc_o <= 1'b0;
         u_stb_o <= 1'b0;
         u_adr_o <= '0;
         u_we_o  <= 1'b0;
         u_dat_o <= '0;
      end else begin
         ack_o <= ack_o ? 1'b0 : stb_i;
         if (wr && adr_i == 2'd0 && !busy) src <= dat_i;
         if (wr && adr_i == 2'd1 && !busy) len <= dat_i[LEN_W-1:0];
         if (wr && adr_i == 2'd2) begin
            irq_en <= dat_i[2];
            if (dat_i[1]) done <= 1'b0;
            if (dat_i[3] && busy) ab <= 1'b1;
            if (dat_i[0] && !busy) begin
               if (len == '0) done <= 1'b1;
               else begin
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  state <= FETCH;
               end
            end
         end
         case (state)
            FETCH:
               if (!m_stb_o) begin
                  if (ab) state <= DONE;
                  else begin
                     m_cyc_o <= 1'b1;
                     m_stb_o <= 1'b1;
                     m_adr_o <= src[31:2];
                  end
               end else if (m_ack_i) begin
                  m_cyc_o <= 1'b0;
                  m_stb_o <= 1'b0;
                  wbuf    <= m_dat_i;
                  state   <= ab ? DONE : POLL;
               end
            POLL:
               if (!u_stb_o) begin
                  if (ab) state <= DONE;
                  else begin
                     u_cyc_o <= 1'b1;
                     u_stb_o <= 1'b1;
                     u_adr_o <= 2'd1;
                     u_we_o  <= 1'b0;
                     u_dat_o <= '0;
                  end
               end else if (u_ack_i) begin
                  u_cyc_o <= 1'b0;
                  u_stb_o <= 1'b0;
                  // the POLL re-entry cycle is itself one idle cycle, so GAP holds POLL_GAP-1
                  if (ab) state <= DONE;
                  else if (!u_dat_i[27]) state <= WRITE;
                  else if (POLL_GAP < 2) state <= POLL;
                  else begin
                     state <= GAP;
                     cnt   <= 32'(POLL_GAP - 2);
                  end
               end
            GAP: begin
               state <= ab ? DONE : cnt == 32'd0 ? POLL : GAP;
               cnt   <= cnt - 32'd1;
            end
            WRITE:
               if (!u_stb_o) begin
                  if (ab) state <= DONE;
                  else begin
                     u_cyc_o <= 1'b1;
                     u_stb_o <= 1'b1;
                     u_adr_o <= 2'd0;
                     u_we_o  <= 1'b1;
                     u_dat_o <= {cur_byte, 24'b0};
                  end
               end else if (u_ack_i) begin
                  u_cyc_o <= 1'b0;
                  u_stb_o <= 1'b0;
                  u_we_o  <= 1'b0;
                  src     <= src + 32'd1;
                  if (len != '0) len <= len - LEN_W'(1);
                  state   <= (ab || len <= LEN_W'(1)) ? DONE :
                             src[1:0] == 2'd3 ? FETCH : POLL;
               end
            DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               ab    <= 1'b0;
               state <= IDLE;
            end
            default: ;
         endcase
      end
   end
endmodule
